// File: rtl/cpu_pkg.sv
// Shared types for the decode-stage operand hazard logic: scoreboard entry
// layout, forwarding-select codes and the scoreboard match helper.
package cpu_pkg;

    localparam int REG_AW = 2;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;
    localparam logic [1:0] FWD_WB    = 2'b11;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] dst;
        logic              ld;
    } sb_entry_t;

    // An operand matches an in-flight writer only when it is actually read.
    function automatic logic sb_hit(input sb_entry_t e, input logic use_op,
                                    input logic [REG_AW-1:0] src);
        return use_op & e.v & (e.dst == src);
    endfunction

endpackage

// File: rtl/hazard_fwd_select.sv
// Youngest-first forwarding source selection for a single source operand.
module hazard_fwd_select
    import cpu_pkg::*;
(
    input  logic              use_op,
    input  logic [REG_AW-1:0] src,
    input  sb_entry_t         ex_e,
    input  sb_entry_t         mem_e,
    input  sb_entry_t         wb_e,
    output logic              hit_ex,
    output logic [1:0]        sel
);

    logic unused_ld;
    assign unused_ld = mem_e.ld ^ wb_e.ld;

    always_comb begin
        hit_ex = sb_hit(ex_e, use_op, src);
        sel    = FWD_RF;
        // A load still in EX cannot forward; the top stalls on it instead.
        if (hit_ex && !ex_e.ld) begin
            sel = FWD_EXMEM;
        end else if (sb_hit(mem_e, use_op, src)) begin
            sel = FWD_MEMWB;
        end else if (sb_hit(wb_e, use_op, src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/operand_hazard_unit.sv
// Load-use stall, ID/EX bubble and registered forwarding selects driven by a
// three-deep (EX/MEM/WB) destination scoreboard, plus a saturating stall counter.
module operand_hazard_unit #(
    parameter int REG_AW = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [1:0]        id_has_hazard,
    input  logic [REG_AW-1:0] id_ra,
    input  logic [REG_AW-1:0] id_rb,
    input  logic              id_wr_en,
    input  logic [REG_AW-1:0] id_wr_dst,
    input  logic              id_is_load,
    input  logic              ex_flush,
    output logic              stall,
    output logic              idex_bubble,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [CNT_W-1:0]  stall_cnt
);

    import cpu_pkg::*;

    sb_entry_t        ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       use_a, use_b;
    logic       hit_ex_a, hit_ex_b;
    logic [1:0] sel_a, sel_b;

    assign use_a = id_valid & id_has_hazard[1];
    assign use_b = id_valid & id_has_hazard[0];

    hazard_fwd_select u_sel_a (
        .use_op (use_a),
        .src    (id_ra),
        .ex_e   (ex_q),
        .mem_e  (mem_q),
        .wb_e   (wb_q),
        .hit_ex (hit_ex_a),
        .sel    (sel_a)
    );

    hazard_fwd_select u_sel_b (
        .use_op (use_b),
        .src    (id_rb),
        .ex_e   (ex_q),
        .mem_e  (mem_q),
        .wb_e   (wb_q),
        .hit_ex (hit_ex_b),
        .sel    (sel_b)
    );

    // A flush squashes the consumer, so it must never also stall.
    assign stall       = ~ex_flush & (hit_ex_a | hit_ex_b) & ex_q.ld;
    assign idex_bubble = stall | ex_flush;

    always_comb begin
        mem_d = ex_q;
        wb_d  = mem_q;
        ex_d  = '0;
        if (!idex_bubble) begin
            ex_d.v   = id_valid & id_wr_en;
            ex_d.dst = id_wr_dst;
            ex_d.ld  = id_is_load;
        end

        fwd_a_d = idex_bubble ? FWD_RF : sel_a;
        fwd_b_d = idex_bubble ? FWD_RF : sel_b;

        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_operand_hazard_unit.sv
// Scoreboard bench for operand_hazard_unit: stimulus pushes expected outputs
// from an instruction-history model; a negedge monitor pops and compares.
module tb_operand_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [1:0] id_has_hazard = 2'b00;
    logic [1:0] id_ra = 2'b00, id_rb = 2'b00, id_wr_dst = 2'b00;
    logic       id_wr_en = 1'b0, id_is_load = 1'b0, ex_flush = 1'b0;

    logic        stall, idex_bubble;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [15:0] stall_cnt;

    logic        s_stall, s_bubble;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [2:0]  s_cnt;

    always #5 clk = ~clk;

    operand_hazard_unit u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_has_hazard(id_has_hazard),
        .id_ra(id_ra), .id_rb(id_rb), .id_wr_en(id_wr_en), .id_wr_dst(id_wr_dst),
        .id_is_load(id_is_load), .ex_flush(ex_flush), .stall(stall),
        .idex_bubble(idex_bubble), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_cnt(stall_cnt)
    );

    // Narrow counter copy so saturation is reachable in a short run.
    operand_hazard_unit #(.REG_AW(2), .CNT_W(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_has_hazard(id_has_hazard),
        .id_ra(id_ra), .id_rb(id_rb), .id_wr_en(id_wr_en), .id_wr_dst(id_wr_dst),
        .id_is_load(id_is_load), .ex_flush(ex_flush), .stall(s_stall),
        .idex_bubble(s_bubble), .fwd_a_sel(s_fwd_a), .fwd_b_sel(s_fwd_b),
        .stall_cnt(s_cnt)
    );

    typedef struct {
        bit v;
        int dst;
        bit ld;
    } ent_t;

    typedef struct {
        bit stall;
        bit bubble;
        int fa;
        int fb;
        int cnt;
    } exp_t;

    ent_t hist[$];   // hist[0] = instruction now in EX, [1] MEM, [2] WB
    exp_t expq[$];
    int   fa_reg, fb_reg, cnt_m;
    int   checks = 0;
    int   failures = 0;

    function automatic int age_hit(input bit use_op, input int src);
        for (int i = 0; i < 3; i++)
            if (use_op && hist[i].v && hist[i].dst == src) return i;
        return -1;
    endfunction

    function automatic void model_clear();
        ent_t z;
        z = '{v: 1'b0, dst: 0, ld: 1'b0};
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_back(z);
        fa_reg = 0;
        fb_reg = 0;
        cnt_m  = 0;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // One ID-stage cycle: drive after the edge, predict, and advance the model.
    task automatic step(input bit v, input bit [1:0] hh, input int ra, input int rb,
                        input bit we, input int wd, input bit ld, input bit fl,
                        input bit rst = 1'b0);
        exp_t e;
        ent_t n;
        int   aa, ab;
        bit   st;
        @(posedge clk);
        #1;
        rst_n         = !rst;
        id_valid      = v;
        id_has_hazard = hh;
        id_ra         = ra[1:0];
        id_rb         = rb[1:0];
        id_wr_en      = we;
        id_wr_dst     = wd[1:0];
        id_is_load    = ld;
        ex_flush      = fl;
        if (rst) begin
            model_clear();
            e = '{stall: 1'b0, bubble: fl, fa: 0, fb: 0, cnt: 0};
            expq.push_back(e);
        end else begin
            aa = age_hit(v & hh[1], ra);
            ab = age_hit(v & hh[0], rb);
            st = !fl && (aa == 0 || ab == 0) && hist[0].ld;
            e  = '{stall: st, bubble: st | fl, fa: fa_reg, fb: fb_reg, cnt: cnt_m};
            expq.push_back(e);
            fa_reg = (st || fl || aa < 0) ? 0 : aa + 1;
            fb_reg = (st || fl || ab < 0) ? 0 : ab + 1;
            if (st) cnt_m++;
            if (st || fl) n = '{v: 1'b0, dst: 0, ld: 1'b0};
            else          n = '{v: v & we, dst: wd, ld: ld};
            hist.push_front(n);
            void'(hist.pop_back());
        end
    endtask

    task automatic nop();
        step(1'b0, 2'b00, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic indep();
        step(1'b1, 2'b00, 0, 0, 1'b1, 0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("stall", int'(stall), int'(e.stall));
            chk("idex_bubble", int'(idex_bubble), int'(e.bubble));
            chk("fwd_a_sel", int'(fwd_a_sel), e.fa);
            chk("fwd_b_sel", int'(fwd_b_sel), e.fb);
            chk("stall_cnt", int'(stall_cnt), e.cnt > 65535 ? 65535 : e.cnt);
            chk("sat_stall_cnt", int'(s_cnt), e.cnt > 7 ? 7 : e.cnt);
        end
    end

    initial begin
        model_clear();
        step(1'b0, 2'b00, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);

        // Activity in flight, then asynchronous reset mid-stream.
        step(1'b1, 2'b00, 0, 0, 1'b1, 1, 1'b1, 1'b0);
        step(1'b1, 2'b11, 1, 1, 1'b1, 2, 1'b0, 1'b0);
        step(1'b1, 2'b11, 2, 1, 1'b1, 3, 1'b0, 1'b0);
        step(1'b0, 2'b00, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 2'b00, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);

        // ALU producer then dependent consumer.
        step(1'b1, 2'b00, 0, 0, 1'b1, 1, 1'b0, 1'b0);
        step(1'b1, 2'b11, 1, 0, 1'b0, 0, 1'b0, 1'b0);
        nop();

        // Load-use: one stall, then MEM/WB forward on the retry.
        step(1'b1, 2'b00, 0, 0, 1'b1, 2, 1'b1, 1'b0);
        step(1'b1, 2'b01, 0, 2, 1'b0, 0, 1'b0, 1'b0);
        step(1'b1, 2'b01, 0, 2, 1'b0, 0, 1'b0, 1'b0);
        nop();

        // Distance 3 forwards from WB data; distance 4 reads the regfile.
        step(1'b1, 2'b00, 0, 0, 1'b1, 3, 1'b0, 1'b0);
        indep(); indep();
        step(1'b1, 2'b10, 3, 0, 1'b0, 0, 1'b0, 1'b0);
        step(1'b1, 2'b00, 0, 0, 1'b1, 3, 1'b0, 1'b0);
        indep(); indep(); indep();
        step(1'b1, 2'b10, 3, 0, 1'b0, 0, 1'b0, 1'b0);
        nop();

        // Two writers of R1 in flight: the younger one wins.
        step(1'b1, 2'b00, 0, 0, 1'b1, 1, 1'b0, 1'b0);
        step(1'b1, 2'b00, 0, 0, 1'b1, 1, 1'b0, 1'b0);
        step(1'b1, 2'b11, 1, 1, 1'b0, 0, 1'b0, 1'b0);
        nop();

        // Flush coinciding with load-use; squashed writer must not forward.
        step(1'b1, 2'b00, 0, 0, 1'b1, 2, 1'b1, 1'b0);
        step(1'b1, 2'b01, 0, 2, 1'b1, 3, 1'b0, 1'b1);
        step(1'b1, 2'b10, 3, 0, 1'b0, 0, 1'b0, 1'b0);
        nop();

        // Operands not read: no stall, no forwarding, despite matching dsts.
        step(1'b1, 2'b00, 0, 0, 1'b1, 0, 1'b0, 1'b0);
        step(1'b1, 2'b00, 0, 0, 1'b1, 1, 1'b0, 1'b0);
        step(1'b1, 2'b00, 0, 0, 1'b1, 2, 1'b1, 1'b0);
        step(1'b1, 2'b00, 2, 2, 1'b0, 0, 1'b0, 1'b0);
        nop();

        // Repeated load-use pairs drive the narrow counter into saturation.
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 2'b00, 0, 0, 1'b1, i % 4, 1'b1, 1'b0);
            step(1'b1, 2'b10, i % 4, 0, 1'b0, 0, 1'b0, 1'b0);
        end
        nop();

        // Randomised instruction stream with occasional flushes and resets.
        for (int i = 0; i < 3000; i++) begin
            bit r;
            r = ($urandom_range(0, 199) == 0);
            step($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3),
                 $urandom_range(0, 2) == 0, !r && $urandom_range(0, 14) == 0, r);
        end
        nop();
        nop();

        for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
        #2;
        if (expq.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expected entries left, required 0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/operand_hazard_unit.md
Name: operand_hazard_unit

Overview:
- Consumes the per-instruction operand-usage code from the decode-stage hazard control (has_hazard: bit1 = operand A/ra read, bit0 = operand B/rb read).
- Tracks destination registers in flight in EX, MEM and WB with a 3-entry shift scoreboard.
- Produces the load-use stall, the ID/EX bubble, and registered forwarding selects applied during the consumer's EX stage.
- Keeps a saturating stall counter for performance debug.

Parameters:
- REG_AW, 2, register-index width (ra/rb/dst).
- CNT_W, 16, stall-counter width.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_has_hazard  in  2  operand usage from decode; bit1 = reads ra (A), bit0 = reads rb (B)
- id_ra  in  REG_AW  operand A register index
- id_rb  in  REG_AW  operand B register index
- id_wr_en  in  1  ID instruction writes a register
- id_wr_dst  in  REG_AW  destination index
- id_is_load  in  1  result available only after MEM
- ex_flush  in  1  taken branch/jump resolved in EX; squash ID
- stall  out  1  hold PC and IF/ID (combinational)
- idex_bubble  out  1  insert NOP into ID/EX (combinational)
- fwd_a_sel  out  2  registered operand-A source for EX: 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 WB write data
- fwd_b_sel  out  2  same for operand B
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Scoreboard entries EX, MEM, WB, each {v, dst, ld}. Reset: all v=0, dst=0, ld=0.
- Every cycle: WB<=MEM, MEM<=EX.
  - EX<={id_valid & id_wr_en, id_wr_dst, id_is_load} when neither stall nor ex_flush.
  - Otherwise EX<=invalid (bubble).
- Match definitions:
  - useA = id_valid & id_has_hazard[1]
  - useB = id_valid & id_has_hazard[0]
  - hitX_A = useA & X.v & X.dst==id_ra; same pattern for B.
- Load-use: stall = ~ex_flush & ((hitEX_A | hitEX_B) & EX.ld). Exactly one stall cycle per load-use; on the next cycle the load sits in MEM and forwards via 10.
- idex_bubble = stall | ex_flush.
- ex_flush has priority over stall. The ID instruction is squashed, not recorded, and no stall is raised.
- Forward select priority, youngest first:
  - hitEX (non-load) -> 01
  - else hitMEM -> 10
  - else hitWB -> 11
  - else 00
  - Unused operand -> 00.
- Forward selects are registered: value computed in ID at cycle n appears on fwd_*_sel at cycle n+1.
  - If stall or ex_flush at cycle n, register 00 (the bubble uses no forwarding).
- Register 0 is an ordinary register; no zero-register exemption.
- stall_cnt increments on each cycle with stall=1 and saturates at all-ones.
- Reset mid-operation: all state clears immediately (async). Outputs after reset: stall=0, idex_bubble=0, fwd_*_sel=00, stall_cnt=0.
- A simultaneous flush and load-use on the same cycle counts no stall.

Decomposition:
- Shared package (cpu_pkg): REG_AW, FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10, FWD_WB=2'b11, and a sb_entry struct {v, dst, ld}.
- One natural sub-module, hazard_fwd_select: combinational priority select for one operand, instantiated twice (A, B).
- Scoreboard, stall logic and counter stay in the top.

Test Plan:
1. Reset with rst_n=0 mid-stream -> all outputs 0, scoreboard empty. Then ADD R1 (wr_dst=1) followed by ADD reading ra=1, has_hazard=2'b11 -> fwd_a_sel=01 one cycle after the consumer is in ID, stall=0.
2. LOAD R2 (id_is_load=1) followed by a consumer with rb=2, has_hazard=2'b01 -> stall=1 and idex_bubble=1 for exactly one cycle. Consumer re-evaluates and gives fwd_b_sel=10; stall_cnt=1.
3. Producer of R3 with two independent instructions between it and a consumer reading ra=3 -> fwd_a_sel=11. With three between -> 00.
4. Writers to R1 in both EX and MEM, consumer reads ra=1 and rb=1 -> both selects 01 (youngest wins).
5. ex_flush=1 in the same cycle as a load-use match -> stall=0, idex_bubble=1, stall_cnt unchanged. The next cycle shows the EX entry invalid (no forward to a later reader).
6. Consumer with has_hazard=2'b00 matching every in-flight dst -> stall=0, selects 00. Force stall_cnt to saturate at 16'hFFFF; an extra stall leaves it at 16'hFFFF.
